execute_muldiv_stage: RTL and testbench

Execute stage of the five-stage RV32IM pipeline, directly upstream of the memory stage and feeding its ALU-result, store-data, control and PC inputs. Computes single-cycle RV32I ALU results combinationally and runs RV32M multiply/divide/remainder on an iterative 32-step unit. While that unit is busy, the stage stalls the front end and emits bubbles downstream.

---
 rtl/execute_muldiv_stage_pkg.sv | 63 ++++++
 rtl/execute_muldiv_stage_muldiv_unit.sv | 169 ++++++++++++++++
 rtl/execute_muldiv_stage.sv | 89 ++++++++
 tb/tb_execute_muldiv_stage.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/execute_muldiv_stage_pkg.sv
// -----------------------------------------------------------------------------
// execute_muldiv_stage_pkg
// Shared types for the RV32IM execute stage: ALU operation encoding, RV32M
// operation encoding (funct3 order), the decoded control bundle carried from
// ID through EX into MEM, and the iterative mul/div FSM state type.
// -----------------------------------------------------------------------------
package execute_muldiv_stage_pkg;

  localparam int XLEN = 32;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9,
    ALU_LUI  = 4'd10
  } alu_op_type;

  // Encoded exactly as the RV32M funct3 field.
  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } muldiv_op_type;

  typedef struct packed {
    logic          alu_src;     // 1: operand B is the immediate
    alu_op_type    alu_op;
    logic          muldiv_en;   // instruction is an RV32M op
    muldiv_op_type muldiv_op;
    logic          mem_read;
    logic          mem_write;
    logic          reg_write;
    logic          mem_to_reg;
  } control_type;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_DONE = 2'd2
  } muldiv_state_type;

  // funct3[2] separates the divide family from the multiply family.
  function automatic logic op_is_div(input logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic op_is_rem(input logic [2:0] op);
    return op[2] & op[1];
  endfunction

endpackage

// File: rtl/execute_muldiv_stage_muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
// Iterative RV32M multiply/divide/remainder. Works on operand magnitudes for
// 32 steps (shift-add for MUL*, restoring subtract for DIV*/REM*) and applies
// the sign correction when the result is presented in DONE.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   i_start      RV32M instruction present in EX
//   i_flush      squash; forces IDLE next cycle
//   i_op         RV32M operation (funct3)
//   i_a, i_b     rs1 / rs2 operands
//   o_busy       unit is holding the pipeline (latch cycle or RUN)
//   o_done       result valid this cycle (DONE state)
//   o_result     sign-corrected result, meaningful while o_done=1
// -----------------------------------------------------------------------------
module muldiv_unit
  import execute_muldiv_stage_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_start,
  input  logic          i_flush,
  input  muldiv_op_type i_op,
  input  logic [31:0]   i_a,
  input  logic [31:0]   i_b,
  output logic          o_busy,
  output logic          o_done,
  output logic [31:0]   o_result
);

  muldiv_state_type r_state;
  muldiv_state_type w_state_next;

  logic [4:0]    r_cnt;
  logic [63:0]   r_acc;          // MUL: {partial product, multiplier}; DIV: {remainder, quotient}
  logic [31:0]   r_opd;          // MUL: multiplicand magnitude; DIV: divisor magnitude
  muldiv_op_type r_op;
  logic          r_neg;
  logic          r_special;
  logic [31:0]   r_special_val;

  logic        w_accept;
  logic        w_is_div;
  logic        w_a_signed;
  logic        w_b_signed;
  logic        w_a_neg;
  logic        w_b_neg;
  logic        w_neg;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic        w_special;
  logic [31:0] w_special_val;

  logic [32:0] w_sum;
  logic [32:0] w_shift;
  logic        w_ge;
  logic [31:0] w_rem;
  logic [63:0] w_acc_step;

  logic [63:0] w_prod;
  logic [31:0] w_quo;
  logic [31:0] w_rmd;

  assign w_accept   = (r_state == MD_IDLE) && i_start && !i_flush;
  assign w_is_div   = op_is_div(i_op);
  assign w_a_signed = (i_op == MD_MULH) || (i_op == MD_MULHSU) ||
                      (i_op == MD_DIV)  || (i_op == MD_REM);
  assign w_b_signed = (i_op == MD_MULH) || (i_op == MD_DIV) || (i_op == MD_REM);
  assign w_a_neg    = w_a_signed & i_a[31];
  assign w_b_neg    = w_b_signed & i_b[31];
  assign w_a_mag    = w_a_neg ? -i_a : i_a;
  assign w_b_mag    = w_b_neg ? -i_b : i_b;
  // Remainder follows the dividend; product and quotient follow the sign xor.
  assign w_neg      = op_is_rem(i_op) ? w_a_neg : (w_a_neg ^ w_b_neg);

  // Corner cases resolved at latch; the iteration still runs to keep latency fixed.
  always_comb begin
    w_special     = 1'b0;
    w_special_val = '0;
    if (w_is_div && (i_b == 32'd0)) begin
      w_special     = 1'b1;
      w_special_val = op_is_rem(i_op) ? i_a : 32'hFFFF_FFFF;
    end else if (((i_op == MD_DIV) || (i_op == MD_REM)) &&
                 (i_a == 32'h8000_0000) && (i_b == 32'hFFFF_FFFF)) begin
      w_special     = 1'b1;
      w_special_val = op_is_rem(i_op) ? 32'd0 : 32'h8000_0000;
    end
  end

  // One iteration step. Multiply adds the multiplicand into the upper half when
  // the current multiplier LSB is set, then shifts right with the carry.
  // Divide shifts the next dividend bit into the remainder and subtracts the
  // divisor when it fits; the remainder then stays below the divisor, so 32 bits hold it.
  always_comb begin
    w_sum   = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opd} : 33'd0);
    w_shift = {r_acc[63:32], r_acc[31]};
    w_ge    = (w_shift >= {1'b0, r_opd});
    w_rem   = w_ge ? 32'(w_shift - {1'b0, r_opd}) : w_shift[31:0];
    if (op_is_div(r_op)) begin
      w_acc_step = {w_rem, r_acc[30:0], w_ge};
    end else begin
      w_acc_step = {w_sum, r_acc[31:1]};
    end
  end

  always_comb begin
    w_prod = r_neg ? -r_acc : r_acc;
    w_quo  = r_neg ? -r_acc[31:0] : r_acc[31:0];
    w_rmd  = r_neg ? -r_acc[63:32] : r_acc[63:32];
    case (r_op)
      MD_MUL:                       o_result = w_prod[31:0];
      MD_MULH, MD_MULHSU, MD_MULHU: o_result = w_prod[63:32];
      MD_DIV, MD_DIVU:              o_result = w_quo;
      default:                      o_result = w_rmd;
    endcase
    if (r_special) begin
      o_result = r_special_val;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      MD_IDLE: if (w_accept) w_state_next = MD_RUN;
      MD_RUN:  if (r_cnt == 5'd31) w_state_next = MD_DONE;
      MD_DONE: w_state_next = MD_IDLE;
      default: w_state_next = MD_IDLE;
    endcase
    if (i_flush) begin
      w_state_next = MD_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= MD_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt         <= '0;
      r_acc         <= '0;
      r_opd         <= '0;
      r_op          <= MD_MUL;
      r_neg         <= 1'b0;
      r_special     <= 1'b0;
      r_special_val <= '0;
    end else if (w_accept) begin
      r_cnt         <= '0;
      r_op          <= i_op;
      r_opd         <= w_is_div ? w_b_mag : w_a_mag;
      r_acc         <= {32'd0, (w_is_div ? w_a_mag : w_b_mag)};
      r_neg         <= w_neg;
      r_special     <= w_special;
      r_special_val <= w_special_val;
    end else if (r_state == MD_RUN) begin
      r_cnt <= r_cnt + 5'd1;
      r_acc <= w_acc_step;
    end
  end

  assign o_busy = w_accept || (r_state == MD_RUN);
  assign o_done = (r_state == MD_DONE);

endmodule

// File: rtl/execute_muldiv_stage.sv
// -----------------------------------------------------------------------------
// execute_muldiv_stage
// RV32IM execute stage. Single-cycle ALU results are combinational; RV32M ops
// run on muldiv_unit while the front end is stalled and bubbles go downstream.
//
// Ports:
//   clk, reset_n     clock, asynchronous active-low reset
//   data1_in         rs1 operand (forwarded)
//   data2_in         rs2 operand (forwarded)
//   immediate_in     sign-extended immediate
//   control_in       decoded control for the instruction in EX
//   pc_in            instruction PC
//   flush_in         squash the instruction in EX, including an in-flight mul/div
//   stall_out        hold IF/ID/EX registers
//   control_out      control to MEM; all-zero bubble when not advancing
//   alu_data_out     ALU result, or mul/div result in its DONE cycle
//   memory_data_out  store data (rs2)
//   pc_out           PC passthrough
// -----------------------------------------------------------------------------
module execute_muldiv_stage
  import execute_muldiv_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] data1_in,
  input  logic [31:0] data2_in,
  input  logic [31:0] immediate_in,
  input  control_type control_in,
  input  logic [31:0] pc_in,
  input  logic        flush_in,
  output logic        stall_out,
  output control_type control_out,
  output logic [31:0] alu_data_out,
  output logic [31:0] memory_data_out,
  output logic [31:0] pc_out
);

  logic        [31:0] w_opb;
  logic signed [31:0] w_a_s;
  logic signed [31:0] w_b_s;
  logic        [31:0] w_alu;
  logic               w_md_busy;
  logic               w_md_done;
  logic        [31:0] w_md_result;

  assign w_opb = control_in.alu_src ? immediate_in : data2_in;
  assign w_a_s = data1_in;
  assign w_b_s = w_opb;

  always_comb begin
    w_alu = '0;
    case (control_in.alu_op)
      ALU_ADD:  w_alu = data1_in + w_opb;
      ALU_SUB:  w_alu = data1_in - w_opb;
      ALU_SLL:  w_alu = data1_in << w_opb[4:0];
      ALU_SLT:  w_alu = {31'd0, (w_a_s < w_b_s)};
      ALU_SLTU: w_alu = {31'd0, (data1_in < w_opb)};
      ALU_XOR:  w_alu = data1_in ^ w_opb;
      ALU_SRL:  w_alu = data1_in >> w_opb[4:0];
      ALU_SRA:  w_alu = 32'(w_a_s >>> w_opb[4:0]);
      ALU_OR:   w_alu = data1_in | w_opb;
      ALU_AND:  w_alu = data1_in & w_opb;
      ALU_LUI:  w_alu = w_opb;
      default:  w_alu = '0;
    endcase
  end

  muldiv_unit u_muldiv (
    .clk      (clk),
    .rst_n    (reset_n),
    .i_start  (control_in.muldiv_en),
    .i_flush  (flush_in),
    .i_op     (control_in.muldiv_op),
    .i_a      (data1_in),
    .i_b      (data2_in),
    .o_busy   (w_md_busy),
    .o_done   (w_md_done),
    .o_result (w_md_result)
  );

  // The unit's FSM is already IDLE during reset, but its combinational latch
  // request would still assert; gate it so reset never stalls the front end.
  assign stall_out       = reset_n && w_md_busy;
  assign control_out     = (stall_out || flush_in || !reset_n) ? '0 : control_in;
  assign alu_data_out    = w_md_done ? w_md_result : w_alu;
  assign memory_data_out = data2_in;
  assign pc_out          = pc_in;

endmodule

// File: tb/tb_execute_muldiv_stage.sv
module tb_execute_muldiv_stage;
  import execute_muldiv_stage_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] data1_in, data2_in, immediate_in, pc_in;
  control_type control_in;
  logic        flush_in;
  logic        stall_out;
  control_type control_out;
  logic [31:0] alu_data_out, memory_data_out, pc_out;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  execute_muldiv_stage dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .data1_in        (data1_in),
    .data2_in        (data2_in),
    .immediate_in    (immediate_in),
    .control_in      (control_in),
    .pc_in           (pc_in),
    .flush_in        (flush_in),
    .stall_out       (stall_out),
    .control_out     (control_out),
    .alu_data_out    (alu_data_out),
    .memory_data_out (memory_data_out),
    .pc_out          (pc_out)
  );

  function automatic control_type mk_ctrl(input logic [3:0] aop, input logic src,
                                          input logic md, input logic [2:0] mop,
                                          input logic mw, input logic rw);
    control_type c;
    c           = '0;
    c.alu_op    = alu_op_type'(aop);
    c.alu_src   = src;
    c.muldiv_en = md;
    c.muldiv_op = muldiv_op_type'(mop);
    c.mem_write = mw;
    c.reg_write = rw;
    return c;
  endfunction

  // Reference RV32M semantics built on native 64-bit arithmetic.
  function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    p  = '0;
    case (op)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    control_in = '0;
    flush_in   = 1'b0;
  endtask

  // Returns at the negedge of the first non-stalled cycle; n = stalled cycles, -1 on timeout.
  task automatic wait_done(output int n);
    n = 0;
    @(negedge clk);
    while (stall_out === 1'b1) begin
      n++;
      if (n > 100) begin
        n = -1;
        break;
      end
      @(posedge clk);
      #1;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset_n    = 1'b1;
    flush_in   = 1'b0;
    data1_in   = 32'd4;
    data2_in   = 32'd2;
    immediate_in = '0;
    pc_in      = 32'h40;
    control_in = mk_ctrl(4'd0, 1'b0, 1'b1, 3'd4, 1'b0, 1'b1);
    #1 reset_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (stall_out !== 1'b0) begin
      n_bad++; $display("FAIL reset_stall: got %b want 0", stall_out);
    end
    n_cmp++;
    if (control_out !== control_type'('0)) begin
      n_bad++; $display("FAIL reset_bubble: got %h want 0", control_out);
    end
    @(posedge clk);
    #1;
    reset_n    = 1'b1;
    control_in = mk_ctrl(4'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
    @(negedge clk);
    n_cmp++;
    if (stall_out !== 1'b0 || control_out !== control_in) begin
      n_bad++; $display("FAIL post_reset: stall %b ctrl %h want 0 / %h", stall_out, control_out, control_in);
    end
    idle();
  endtask

  task automatic test_alu();
    logic [3:0]  aop [11] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10};
    logic [31:0] d1  [11] = '{32'd5, 32'd5, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hF0F0_F0F0,
                              32'h8000_0000, 32'h8000_0000, 32'h0F, 32'h0F0F, 32'h0};
    logic [31:0] d2  [11] = '{32'hFFFF_FFFD, 32'd7, 32'h0, 32'd1, 32'd1, 32'hFF00_FF00,
                              32'd4, 32'd4, 32'hF0, 32'h00FF, 32'h5};
    logic [31:0] imm [11] = '{32'd0, 32'd0, 32'h3F, 32'd0, 32'd0, 32'd0,
                              32'd0, 32'd0, 32'd0, 32'd0, 32'h1234_5000};
    logic        src [11] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [31:0] ex  [11] = '{32'd2, 32'hFFFF_FFFE, 32'h8000_0000, 32'd1, 32'd0, 32'h0FF0_0FF0,
                              32'h0800_0000, 32'hF800_0000, 32'hFF, 32'h000F, 32'h1234_5000};
    logic [31:0] e;
    for (int i = 0; i < 11; i++) begin
      cyc();
      data1_in     = d1[i];
      data2_in     = d2[i];
      immediate_in = imm[i];
      pc_in        = 32'h100 + 32'(i * 4);
      control_in   = mk_ctrl(aop[i], src[i], 1'b0, 3'd0, 1'b0, 1'b1);
      exp_q.push_back(ex[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++;
      if (alu_data_out !== e) begin
        n_bad++; $display("FAIL alu_op%0d: got %h want %h", i, alu_data_out, e);
      end
      n_cmp++;
      if (stall_out !== 1'b0 || control_out !== control_in) begin
        n_bad++; $display("FAIL alu_pass%0d: stall %b ctrl %h want 0 / %h", i, stall_out, control_out, control_in);
      end
      n_cmp++;
      if (memory_data_out !== d2[i] || pc_out !== 32'h100 + 32'(i * 4)) begin
        n_bad++; $display("FAIL alu_thru%0d: memdata %h pc %h want %h / %h", i, memory_data_out, pc_out, d2[i], 32'h100 + 32'(i * 4));
      end
    end
    idle();
  endtask

  task automatic test_mulh();
    int          n;
    logic [31:0] e;
    cyc();
    data1_in   = 32'h8000_0000;
    data2_in   = 32'h8000_0000;
    control_in = mk_ctrl(4'd0, 1'b0, 1'b1, 3'd1, 1'b0, 1'b1);
    exp_q.push_back(32'h4000_0000);
    wait_done(n);
    e = exp_q.pop_front();
    n_cmp++;
    if (n !== 33) begin
      n_bad++; $display("FAIL mulh_stall: got %0d cycles want 33", n);
    end
    n_cmp++;
    if (alu_data_out !== e || control_out !== control_in) begin
      n_bad++; $display("FAIL mulh_result: got %h ctrl %h want %h / %h", alu_data_out, control_out, e, control_in);
    end
    cyc();
    data1_in   = 32'd10;
    data2_in   = 32'd20;
    control_in = mk_ctrl(4'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
    @(negedge clk);
    n_cmp++;
    if (stall_out !== 1'b0 || control_out !== control_in || alu_data_out !== 32'd30) begin
      n_bad++; $display("FAIL mulh_advance: stall %b ctrl %h data %h want 0 / %h / 0000001e", stall_out, control_out, alu_data_out, control_in);
    end
    idle();
  endtask

  task automatic test_muldiv_table();
    logic [2:0]  op [13] = '{3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6, 3'd0, 3'd3, 3'd2, 3'd1, 3'd4, 3'd6, 3'd5};
    logic [31:0] a  [13] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7, 32'd7, 32'h8000_0000, 32'h8000_0000,
                             32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'd100,
                             32'hFFFF_FFFB, 32'hFFFF_FFFF};
    logic [31:0] b  [13] = '{32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                             32'd3, 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF, 32'hFFFF_FFF9,
                             32'd0, 32'd16};
    logic [31:0] ex [13] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd7, 32'h8000_0000, 32'd0,
                             32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h3FFF_FFFF, 32'hFFFF_FFF2,
                             32'hFFFF_FFFB, 32'h0FFF_FFFF};
    int          n;
    logic [31:0] e;
    for (int i = 0; i < 23; i++) begin
      logic [2:0]  cop;
      logic [31:0] ca, cb;
      if (i < 13) begin
        cop = op[i]; ca = a[i]; cb = b[i];
        exp_q.push_back(ex[i]);
      end else begin
        cop = 3'($urandom_range(0, 7));
        ca  = $urandom;
        cb  = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
        exp_q.push_back(ref_md(cop, ca, cb));
      end
      cyc();
      data1_in   = ca;
      data2_in   = cb;
      pc_in      = 32'h2000 + 32'(i * 4);
      control_in = mk_ctrl(4'd0, 1'b0, 1'b1, cop, 1'b0, 1'b1);
      wait_done(n);
      e = exp_q.pop_front();
      n_cmp++;
      if (alu_data_out !== e) begin
        n_bad++; $display("FAIL md%0d_op%0d: a %h b %h got %h want %h", i, cop, ca, cb, alu_data_out, e);
      end
      n_cmp++;
      if (n !== 33 || control_out !== control_in) begin
        n_bad++; $display("FAIL md%0d_timing: stall %0d ctrl %h want 33 / %h", i, n, control_out, control_in);
      end
    end
    idle();
  endtask

  task automatic test_store_behind_div();
    int          n;
    logic        bad;
    logic [31:0] e;
    cyc();
    data1_in   = 32'd50;
    data2_in   = 32'd5;
    control_in = mk_ctrl(4'd0, 1'b0, 1'b1, 3'd4, 1'b0, 1'b1);
    exp_q.push_back(32'd10);
    n   = 0;
    bad = 1'b0;
    @(negedge clk);
    while (stall_out === 1'b1 && n <= 100) begin
      n++;
      n_cmp++;
      if (control_out !== control_type'('0)) begin
        n_bad++; $display("FAIL div_bubble_c%0d: ctrl %h want 0", n, control_out);
      end
      @(posedge clk);
      #1;
      @(negedge clk);
    end
    e = exp_q.pop_front();
    n_cmp++;
    if (n !== 33 || alu_data_out !== e) begin
      n_bad++; $display("FAIL div_store_result: stall %0d data %h want 33 / %h", n, alu_data_out, e);
    end
    cyc();
    data1_in     = 32'h100;
    data2_in     = 32'hDEAD_BEEF;
    immediate_in = 32'd8;
    control_in   = mk_ctrl(4'd0, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0);
    @(negedge clk);
    n_cmp++;
    if (control_out.mem_write !== 1'b1 || alu_data_out !== 32'h108 || memory_data_out !== 32'hDEAD_BEEF) begin
      n_bad++; $display("FAIL store_advance: mw %b addr %h data %h want 1 / 00000108 / deadbeef", control_out.mem_write, alu_data_out, memory_data_out);
    end
    idle();
  endtask

  task automatic test_flush();
    int n;
    cyc();
    data1_in   = 32'd1000;
    data2_in   = 32'd7;
    control_in = mk_ctrl(4'd0, 1'b0, 1'b1, 3'd4, 1'b0, 1'b1);
    repeat (10) cyc();
    flush_in = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (control_out !== control_type'('0)) begin
      n_bad++; $display("FAIL flush_bubble: ctrl %h want 0", control_out);
    end
    cyc();
    flush_in   = 1'b0;
    data1_in   = 32'd1;
    data2_in   = 32'd2;
    control_in = mk_ctrl(4'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
    @(negedge clk);
    n_cmp++;
    if (stall_out !== 1'b0 || control_out !== control_in || alu_data_out !== 32'd3) begin
      n_bad++; $display("FAIL flush_idle: stall %b ctrl %h data %h want 0 / %h / 00000003", stall_out, control_out, alu_data_out, control_in);
    end
    // A fresh op after the flush must take the full latency; then flush its DONE cycle.
    cyc();
    data1_in   = 32'd6;
    data2_in   = 32'd7;
    control_in = mk_ctrl(4'd0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b1);
    exp_q.push_back(32'd42);
    wait_done(n);
    n_cmp++;
    if (n !== 33 || alu_data_out !== exp_q.pop_front()) begin
      n_bad++; $display("FAIL flush_rerun: stall %0d data %h want 33 / 0000002a", n, alu_data_out);
    end
    flush_in = 1'b1;
    #1;
    n_cmp++;
    if (control_out !== control_type'('0)) begin
      n_bad++; $display("FAIL flush_done: ctrl %h want 0", control_out);
    end
    cyc();
    flush_in   = 1'b0;
    data1_in   = 32'd1;
    data2_in   = 32'd2;
    control_in = mk_ctrl(4'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
    @(negedge clk);
    n_cmp++;
    if (stall_out !== 1'b0 || alu_data_out !== 32'd3) begin
      n_bad++; $display("FAIL flush_done_after: stall %b data %h want 0 / 00000003", stall_out, alu_data_out);
    end
    idle();
  endtask

  task automatic test_reset_mid_run();
    logic bad;
    cyc();
    data1_in   = 32'd99;
    data2_in   = 32'd3;
    control_in = mk_ctrl(4'd0, 1'b0, 1'b1, 3'd5, 1'b0, 1'b1);
    repeat (5) cyc();
    @(negedge clk);
    n_cmp++;
    if (stall_out !== 1'b1) begin
      n_bad++; $display("FAIL run_stall: got %b want 1", stall_out);
    end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if (stall_out !== 1'b0 || control_out !== control_type'('0)) begin
      n_bad++; $display("FAIL reset_mid_run: stall %b ctrl %h want 0 / 0", stall_out, control_out);
    end
    @(posedge clk);
    #1;
    reset_n    = 1'b1;
    data1_in   = 32'd9;
    data2_in   = 32'd1;
    control_in = mk_ctrl(4'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
    bad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (alu_data_out !== 32'd10 || stall_out !== 1'b0) bad = 1'b1;
      cyc();
    end
    n_cmp++;
    if (bad !== 1'b0) begin
      n_bad++; $display("FAIL reset_no_emit: saw stall or stale result, last data %h want 0000000a", alu_data_out);
    end
    idle();
  endtask

  task automatic test_back_to_back();
    int          n;
    logic [31:0] e;
    cyc();
    data1_in   = 32'd3;
    data2_in   = 32'd4;
    control_in = mk_ctrl(4'd0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b1);
    exp_q.push_back(32'd12);
    wait_done(n);
    e = exp_q.pop_front();
    n_cmp++;
    if (n !== 33 || alu_data_out !== e) begin
      n_bad++; $display("FAIL b2b_first: stall %0d data %h want 33 / %h", n, alu_data_out, e);
    end
    cyc();
    data1_in   = 32'hFFFF_FFFF;
    data2_in   = 32'd2;
    control_in = mk_ctrl(4'd0, 1'b0, 1'b1, 3'd3, 1'b0, 1'b1);
    exp_q.push_back(32'd1);
    wait_done(n);
    e = exp_q.pop_front();
    n_cmp++;
    if (n !== 33 || alu_data_out !== e || control_out !== control_in) begin
      n_bad++; $display("FAIL b2b_second: stall %0d data %h ctrl %h want 33 / %h / %h", n, alu_data_out, control_out, e, control_in);
    end
    cyc();
    idle();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_mulh();
    test_muldiv_table();
    test_store_behind_div();
    test_flush();
    test_reset_mid_run();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
